alu_arbiter: RTL and testbench

//  Shares one ALU instance between two requesters (r0: decode/execute path, r1: address/aux path).

---
 rtl/alu_arbiter.sv | 146 ++++++++++++++
 tb/tb_alu_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one combinational ALU between
//               two requesters. The winner's operands are registered onto the
//               ALU inputs, the result and zero flag are captured one cycle
//               later, and both are returned on the winner's response port
//               with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW = 32,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // requester 0 (decode/execute path)
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [CW-1:0] r0_ctrl,
    input  logic [DW-1:0] r0_a,
    input  logic [DW-1:0] r0_b,
    output logic          r0_rsp_valid,
    input  logic          r0_rsp_ready,
    // requester 1 (address/aux path)
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [CW-1:0] r1_ctrl,
    input  logic [DW-1:0] r1_a,
    input  logic [DW-1:0] r1_b,
    output logic          r1_rsp_valid,
    input  logic          r1_rsp_ready,
    // shared response payload
    output logic [DW-1:0] rsp_result,
    output logic          rsp_zero,
    // ALU interface
    output logic [CW-1:0] alu_ctrl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero,
    // status
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    logic          r_cur;        // requester owning the op in flight (0/1)
    logic          r_last_gnt;   // requester granted most recently
    logic [CW-1:0] r_alu_ctrl;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic [DW-1:0] r_rsp_result;
    logic          r_rsp_zero;

    logic          w_any;
    logic          w_gnt;
    logic          w_accept;

    // Arbitration: a sole requester wins; on a tie the one not granted last wins.
    assign w_any    = r0_valid | r1_valid;
    assign w_gnt    = (r0_valid && r1_valid) ? ~r_last_gnt : r1_valid;
    assign w_accept = (r_state == S_IDLE) && w_any;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; ready only in IDLE, rsp_valid only in RESP.
    always_comb begin
        w_next_state = r_state;
        r0_ready     = 1'b0;
        r1_ready     = 1'b0;
        r0_rsp_valid = 1'b0;
        r1_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    r0_ready     = ~w_gnt;
                    r1_ready     = w_gnt;
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                r0_rsp_valid = ~r_cur;
                r1_rsp_valid = r_cur;
                if ((r_cur && r1_rsp_ready) || (!r_cur && r0_rsp_ready)) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Operand issue on accept and result capture at the end of EXEC;
    // ALU inputs hold their last values otherwise so the ALU does not toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur        <= 1'b0;
            r_last_gnt   <= 1'b1;
            r_alu_ctrl   <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cur      <= w_gnt;
                r_last_gnt <= w_gnt;
                r_alu_ctrl <= w_gnt ? r1_ctrl : r0_ctrl;
                r_alu_a    <= w_gnt ? r1_a    : r0_a;
                r_alu_b    <= w_gnt ? r1_b    : r0_b;
            end
            if (r_state == S_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_zero   <= alu_zero;
            end
        end
    end

    assign alu_ctrl   = r_alu_ctrl;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter. The bench plays the ALU,
//               drives both requesters and keeps a transaction-level model
//               (grant rule, op latency, expected result) in a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    vld = 2'b00;
    logic [1:0]    rdy;
    logic [CW-1:0] ctl [2];
    logic [DW-1:0] opa [2];
    logic [DW-1:0] opb [2];
    logic [1:0]    rsp_v;
    logic [1:0]    rsp_r = 2'b11;
    logic [DW-1:0] rsp_result;
    logic          rsp_zero;
    logic [CW-1:0] alu_ctrl;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_arbiter #(.DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .r0_valid     (vld[0]),
        .r0_ready     (rdy[0]),
        .r0_ctrl      (ctl[0]),
        .r0_a         (opa[0]),
        .r0_b         (opb[0]),
        .r0_rsp_valid (rsp_v[0]),
        .r0_rsp_ready (rsp_r[0]),
        .r1_valid     (vld[1]),
        .r1_ready     (rdy[1]),
        .r1_ctrl      (ctl[1]),
        .r1_a         (opa[1]),
        .r1_b         (opb[1]),
        .r1_rsp_valid (rsp_v[1]),
        .r1_rsp_ready (rsp_r[1]),
        .rsp_result   (rsp_result),
        .rsp_zero     (rsp_zero),
        .alu_ctrl     (alu_ctrl),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .busy         (busy)
    );

    // ALU behaviour: returns {zero, result}; zero is only produced for add/sub.
    function automatic logic [DW:0] alu_fn(input logic [CW-1:0] c, input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic [DW-1:0] r;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1000: r = x << y[4:0];
            4'b1001: r = x >> y[4:0];
            4'b1100: r = ~(x | y);
            default: r = x ^ y;
        endcase
        return {((c == 4'b0010 || c == 4'b0110) && r == '0), r};
    endfunction

    assign {alu_zero, alu_result} = alu_fn(alu_ctrl, alu_a, alu_b);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard / transaction model ----------------
    typedef struct {
        int            req;
        logic [DW-1:0] res;
        logic          z;
        int            acc;
    } exp_t;

    exp_t          sb [$];
    int            gnt_log [$];
    int            acc_log [$];
    logic [DW-1:0] res_log [$];
    logic          z_log [$];
    bit            m_last = 1'b1;
    int            v1_cnt = 0;
    logic [1:0]    m_exp_rdy;
    logic [1:0]    m_exp_rsp;
    int            m_n;
    int            m_w;
    logic [DW:0]   m_r;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_last = 1'b1;
        end else begin
            m_n = sb.size();
            // grant rule: only with nothing in flight; sole requester, else round-robin
            m_exp_rdy = 2'b00;
            if (m_n == 0 && vld != 2'b00) begin
                if (vld == 2'b11) m_exp_rdy = m_last ? 2'b01 : 2'b10;
                else              m_exp_rdy = vld;
            end
            chk("ready", {62'd0, rdy}, {62'd0, m_exp_rdy});
            chk("busy", {63'd0, busy}, {63'd0, (m_n != 0)});
            if (m_exp_rdy != 2'b00) begin
                m_w = m_exp_rdy[1] ? 1 : 0;
                m_r = alu_fn(ctl[m_w], opa[m_w], opb[m_w]);
                sb.push_back('{req: m_w, res: m_r[DW-1:0], z: m_r[DW], acc: cyc});
                m_last = (m_w == 1);
                gnt_log.push_back(m_w);
                acc_log.push_back(cyc);
            end
            // response: owner's rsp_valid from two cycles after its ready cycle
            m_exp_rsp = 2'b00;
            if (m_n != 0 && cyc >= sb[0].acc + 2)
                m_exp_rsp = (sb[0].req == 1) ? 2'b10 : 2'b01;
            chk("rsp_valid", {62'd0, rsp_v}, {62'd0, m_exp_rsp});
            if (rsp_v[1]) v1_cnt++;
            if (m_exp_rsp != 2'b00 && rsp_v == m_exp_rsp) begin
                chk("rsp_result", {32'd0, rsp_result}, {32'd0, sb[0].res});
                chk("rsp_zero", {63'd0, rsp_zero}, {63'd0, sb[0].z});
                if (rsp_r[sb[0].req]) begin
                    res_log.push_back(rsp_result);
                    z_log.push_back(rsp_zero);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [CW-1:0] rand_op();
        logic [CW-1:0] ops [8];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1100};
        return ops[$urandom_range(0, 7)];
    endfunction

    // Present a request and hold it until accepted; call at posedge+1.
    task automatic issue(input int n, input logic [CW-1:0] c, input logic [DW-1:0] x, input logic [DW-1:0] y);
        int t;
        t = 0;
        ctl[n] = c;
        opa[n] = x;
        opb[n] = y;
        vld[n] = 1'b1;
        @(negedge clk);
        while (!rdy[n] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[n]) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout req=%0d actual=no_ready required=ready", n);
        end
        @(posedge clk);
        #1;
        vld[n] = 1'b0;
    endtask

    task automatic issue_rand(input int n);
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        x = $urandom;
        y = ($urandom_range(0, 3) == 0) ? x : $urandom;
        issue(n, rand_op(), x, y);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || vld != 2'b00) && t < 300) begin
            @(posedge clk);
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    bit rnd_on;

    initial begin
        for (int i = 0; i < 2; i++) begin
            ctl[i] = '0;
            opa[i] = '0;
            opb[i] = '0;
        end
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {62'd0, rdy}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp_valid", {62'd0, rsp_v}, 64'd0);
        chk("rst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        chk("rst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("rst_alu_b", {32'd0, alu_b}, 64'd0);
        chk("rst_result", {32'd0, rsp_result}, 64'd0);
        chk("rst_zero", {63'd0, rsp_zero}, 64'd0);
        rst_n = 1'b1;

        // single r0 add
        issue(0, 4'b0010, 32'd5, 32'd7);
        drain();
        chk("add_result", {32'd0, res_log[$]}, 64'd12);
        chk("add_zero", {63'd0, z_log[$]}, 64'd0);

        // asynchronous reset mid-EXEC drops the op in flight
        issue(0, 4'b0010, 32'hFFFF_0000, 32'h0000_1234);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_rsp_valid", {62'd0, rsp_v}, 64'd0);
        chk("arst_alu_a", {32'd0, alu_a}, 64'd0);
        chk("arst_alu_ctrl", {60'd0, alu_ctrl}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // both requesters valid right after reset: r0 first
        fork
            issue(0, 4'b0110, 32'd9, 32'd9);
            issue(1, 4'b0000, 32'hF0, 32'h3C);
        join
        drain();
        chk("tie_first_gnt", gnt_log[$-1], 64'd0);
        chk("tie_second_gnt", gnt_log[$], 64'd1);
        chk("sub_result", {32'd0, res_log[$-1]}, 64'd0);
        chk("sub_zero", {63'd0, z_log[$-1]}, 64'd1);
        chk("and_result", {32'd0, res_log[$]}, 64'h30);
        chk("and_zero", {63'd0, z_log[$]}, 64'd0);
        chk("r1_wait_one_op", acc_log[$] - acc_log[$-1], 64'd3);

        // back-pressure on r1 while r0 waits
        rsp_r[1] = 1'b0;
        v1_cnt = 0;
        fork
            issue(1, 4'b0010, $urandom, $urandom);
            begin
                repeat (2) @(posedge clk);
                #1;
                issue(0, 4'b0110, $urandom, $urandom);
            end
            begin
                int t;
                t = 0;
                @(negedge clk);
                while (!rsp_v[1] && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                repeat (5) @(posedge clk);
                #1;
                rsp_r[1] = 1'b1;
            end
        join
        drain();
        chk("bp_rsp_valid_cycles", v1_cnt, 64'd6);
        chk("bp_gnt_order", {gnt_log[$-1], gnt_log[$]}, {32'd1, 32'd0});
        chk("bp_r0_gap", acc_log[$] - acc_log[$-1], 64'd8);

        // fairness under continuous demand from both
        pulse_reset();
        fork
            for (int i = 0; i < 3; i++) issue_rand(0);
            for (int i = 0; i < 3; i++) issue_rand(1);
        join
        drain();
        for (int i = 0; i < 6; i++) begin
            chk("fair_gnt", gnt_log[gnt_log.size() - 6 + i], i % 2);
            if (i > 0) chk("fair_gap", acc_log[acc_log.size() - 6 + i] - acc_log[acc_log.size() - 7 + i], 64'd3);
        end

        // shift and back-to-back issue interval
        issue(1, 4'b1000, 32'd1, 32'd31);
        issue_rand(1);
        drain();
        chk("sll_result", {32'd0, res_log[$-1]}, 64'h8000_0000);
        chk("b2b_gap", acc_log[$] - acc_log[$-1], 64'd3);

        // randomized traffic with random response back-pressure
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clk);
                #1;
                rsp_r = 2'($urandom);
            end
            begin
                fork
                    for (int i = 0; i < 25; i++) begin
                        int g;
                        g = $urandom_range(0, 3);
                        if (g > 0) begin
                            repeat (g) @(posedge clk);
                            #1;
                        end
                        issue_rand(0);
                    end
                    for (int i = 0; i < 25; i++) begin
                        int g;
                        g = $urandom_range(0, 3);
                        if (g > 0) begin
                            repeat (g) @(posedge clk);
                            #1;
                        end
                        issue_rand(1);
                    end
                join
                rnd_on = 1'b0;
            end
        join
        rsp_r = 2'b11;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
